// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: req/ack data-memory access with stall, plus the MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN adds misalign_o and suppresses misaligned accesses.
module mem_stage_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        WB_i,
    input  logic [1:0]        M_i,
    input  logic [DATA_W-1:0] ALUresult_i,
    input  logic [DATA_W-1:0] WriteData_i,
    input  logic [REG_W-1:0]  RegRD_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [1:0]        WB_o,
    output logic [DATA_W-1:0] MemData_o,
    output logic [DATA_W-1:0] ALUresult_o,
    output logic [REG_W-1:0]  RegRD_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, next_state;
    logic              mem_op_c;
    logic              misalign_c;
    logic              start_c;
    logic              stall_c;
    logic [DATA_W-1:0] rdata_q;

    assign mem_op_c = |M_i;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = |ALUresult_i[1:0];
`else
    assign misalign_c = 1'b0;
`endif
    assign start_c = mem_op_c & ~misalign_c;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and stall
    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start_c) begin
                    stall_c    = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (mem_ack_i) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Gated by reset so a pending op in IDLE cannot hold stall during reset
    assign stall_o = stall_c & ~rst_i;

    // Memory port latches and MEM/WB register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_q     <= '0;
            WB_o        <= '0;
            MemData_o   <= '0;
            ALUresult_o <= '0;
            RegRD_o     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_c) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= M_i[0];
                        mem_addr_o  <= ALUresult_i;
                        mem_wdata_o <= WriteData_i;
                        WB_o        <= '0;
                        MemData_o   <= '0;
                        ALUresult_o <= '0;
                        RegRD_o     <= '0;
                    end else begin
                        WB_o        <= misalign_c ? 2'b00 : WB_i;
                        MemData_o   <= '0;
                        ALUresult_o <= ALUresult_i;
                        RegRD_o     <= RegRD_i;
`ifdef MEM_ALIGN_CHECK_EN
                        misalign_o  <= mem_op_c & misalign_c;
`endif
                    end
                end
                ACCESS: begin
                    WB_o        <= '0;
                    MemData_o   <= '0;
                    ALUresult_o <= '0;
                    RegRD_o     <= '0;
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        rdata_q   <= mem_we_o ? '0 : mem_rdata_i;
                    end
                end
                DONE: begin
                    WB_o        <= WB_i;
                    MemData_o   <= rdata_q;
                    ALUresult_o <= ALUresult_i;
                    RegRD_o     <= RegRD_i;
                end
                default: ;
            endcase
        end
    end

endmodule
